// File: rtl/vram_arbiter.sv
// Arbitrates the single-port video RAM between the gfx line fetcher (absolute priority) and the CPU bus.
// Latency with gfx idle: CPU read ack at T+2, write ack at T+1 after the request cycle.
// Backpressure: gfx never stalls; the CPU waits on cpu_req until cpu_ack. Optional VRAM_WRBUF_EN posts writes.
module vram_arbiter #(
    parameter int WRBUF_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        gfx_active,
    input  logic [13:0] gfx_addr,
    output logic [15:0] gfx_rddata,
    input  logic        cpu_req,
    input  logic        cpu_wren,
    input  logic [13:0] cpu_addr,
    input  logic [15:0] cpu_wrdata,
    input  logic [1:0]  cpu_bytesel,
    output logic        cpu_ack,
    output logic [15:0] cpu_rddata,
    output logic [13:0] ram_addr,
    output logic [15:0] ram_wrdata,
    output logic [1:0]  ram_wrsel,
    output logic        ram_wren,
`ifdef VRAM_WRBUF_EN
    output logic        wrbuf_empty,
`endif
    input  logic [15:0] ram_rddata
);

    // Reject depths the pointer arithmetic cannot handle (must be a power of 2 in 2..16).
    if (WRBUF_DEPTH < 2 || WRBUF_DEPTH > 16 || (WRBUF_DEPTH & (WRBUF_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("vram_arbiter: WRBUF_DEPTH must be a power of 2 in 2..16");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cpu_rddata_q, cpu_rddata_d;

    // RAM read data goes straight back to gfx; it owns the timing of its own fetches.
    assign gfx_rddata = ram_rddata;
    assign cpu_ack    = (state_q == S_ACK);
    assign cpu_rddata = cpu_rddata_q;

`ifdef VRAM_WRBUF_EN
    localparam int PW = $clog2(WRBUF_DEPTH);
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(WRBUF_DEPTH);

    typedef struct packed {
        logic [13:0] addr;
        logic [15:0] data;
        logic [1:0]  sel;
    } wr_entry_t;

    wr_entry_t   wrbuf_mem [WRBUF_DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          push, pop;
    wr_entry_t     head;

    // Admission uses the registered count only, so a same-cycle pop never frees a slot early.
    assign push        = (state_q == S_IDLE) && cpu_req && cpu_wren && (count_q != DEPTH_C);
    assign pop         = !gfx_active && (count_q != '0);
    assign head        = wrbuf_mem[rd_ptr_q];
    assign wrbuf_empty = (count_q == '0);

    // FIFO pointer and occupancy bookkeeping.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        count_d = count_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end

    // FIFO control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO payload storage; contents are meaningless while the slot is not counted.
    always_ff @(posedge clk) begin
        if (push) begin
            wrbuf_mem[wr_ptr_q] <= '{addr: cpu_addr, data: cpu_wrdata, sel: cpu_bytesel};
        end
    end

    // Next-state and RAM port mux: gfx first, then FIFO drain, then a CPU read once the FIFO is empty.
    always_comb begin
        state_d      = state_q;
        cpu_rddata_d = cpu_rddata_q;
        ram_addr     = gfx_addr;
        ram_wrdata   = 16'h0000;
        ram_wrsel    = 2'b00;
        ram_wren     = 1'b0;

        if (pop) begin
            ram_addr   = head.addr;
            ram_wrdata = head.data;
            ram_wrsel  = head.sel;
            ram_wren   = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (cpu_req) begin
                    if (cpu_wren) begin
                        if (push) begin
                            state_d = S_ACK;
                        end
                    end else if (!gfx_active && (count_q == '0)) begin
                        // FIFO empty implies no pop this cycle, so the port is free.
                        ram_addr = cpu_addr;
                        state_d  = S_RD;
                    end
                end
            end
            S_RD: begin
                cpu_rddata_d = ram_rddata;
                state_d      = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
`else
    // Next-state and RAM port mux: gfx owns the port while active; CPU issues only in gfx idle cycles.
    always_comb begin
        state_d      = state_q;
        cpu_rddata_d = cpu_rddata_q;
        ram_addr     = gfx_addr;
        ram_wrdata   = 16'h0000;
        ram_wrsel    = 2'b00;
        ram_wren     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cpu_req && !gfx_active) begin
                    ram_addr = cpu_addr;
                    if (cpu_wren) begin
                        ram_wrdata = cpu_wrdata;
                        ram_wrsel  = cpu_bytesel;
                        ram_wren   = 1'b1;
                        state_d    = S_ACK;
                    end else begin
                        state_d = S_RD;
                    end
                end
            end
            S_RD: begin
                // Port is left to gfx here; the RAM is returning the CPU word.
                cpu_rddata_d = ram_rddata;
                state_d      = S_ACK;
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end
`endif

    // FSM state and CPU read-data holding register; reset drops any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cpu_rddata_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            cpu_rddata_q <= cpu_rddata_d;
        end
    end

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: behavioural VRAM model, reference memory and ack scoreboard.
// Inputs change on the falling edge; outputs are sampled shortly after it.
// VRAM_WRBUF_EN selects the posted-write scenarios.
module tb_vram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        gfx_active;
    logic [13:0] gfx_addr;
    logic [15:0] gfx_rddata;
    logic        cpu_req;
    logic        cpu_wren;
    logic [13:0] cpu_addr;
    logic [15:0] cpu_wrdata;
    logic [1:0]  cpu_bytesel;
    logic        cpu_ack;
    logic [15:0] cpu_rddata;
    logic [13:0] ram_addr;
    logic [15:0] ram_wrdata;
    logic [1:0]  ram_wrsel;
    logic        ram_wren;
    logic [15:0] ram_rddata;
`ifdef VRAM_WRBUF_EN
    logic        wrbuf_empty;
`endif

    vram_arbiter #(.WRBUF_DEPTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .gfx_active  (gfx_active),
        .gfx_addr    (gfx_addr),
        .gfx_rddata  (gfx_rddata),
        .cpu_req     (cpu_req),
        .cpu_wren    (cpu_wren),
        .cpu_addr    (cpu_addr),
        .cpu_wrdata  (cpu_wrdata),
        .cpu_bytesel (cpu_bytesel),
        .cpu_ack     (cpu_ack),
        .cpu_rddata  (cpu_rddata),
        .ram_addr    (ram_addr),
        .ram_wrdata  (ram_wrdata),
        .ram_wrsel   (ram_wrsel),
        .ram_wren    (ram_wren),
`ifdef VRAM_WRBUF_EN
        .wrbuf_empty (wrbuf_empty),
`endif
        .ram_rddata  (ram_rddata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rd;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic [13:0] a;
        logic [15:0] d;
    } wr_t;

    exp_t        exp_q[$];
    wr_t         wr_log[$];
    logic [15:0] mem     [0:16383];
    logic [15:0] ref_mem [0:16383];
    logic        ram_init;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // VRAM model: address sampled at the edge, data back the next cycle, byte-masked writes.
    always @(posedge clk) begin
        if (ram_init) begin
            for (int i = 0; i < 16384; i++) mem[i] <= 16'(i * 7) ^ 16'h5A5A;
            mem[14'h0123] <= 16'hBEEF;
            mem[14'h3F00] <= 16'hABCD;
        end else begin
            if (ram_wren) begin
                if (ram_wrsel[0]) mem[ram_addr][7:0]  <= ram_wrdata[7:0];
                if (ram_wrsel[1]) mem[ram_addr][15:8] <= ram_wrdata[15:8];
            end
            ram_rddata <= mem[ram_addr];
        end
    end

    // Ack scoreboard plus gfx-ownership checks, sampled after the falling edge.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!reset && !ram_init) begin
            if (cpu_ack) begin
                if (exp_q.size() == 0) begin
                    chk_eq("spurious_ack", cpu_ack, 0);
                end else begin
                    e = exp_q.pop_front();
                    if (e.rd) chk_eq("rd_data", cpu_rddata, e.data);
                end
            end
            if (gfx_active) begin
                chk_eq("gfx_addr_mux", ram_addr, gfx_addr);
                chk_eq("gfx_no_wren", ram_wren, 0);
            end
            if (ram_wren) wr_log.push_back('{a: ram_addr, d: ram_wrdata});
        end
    end

    task automatic wait_ack(input int bound, output int lat);
        lat = -1;
        for (int n = 1; n <= bound; n++) begin
            @(negedge clk);
            #1;
            if (cpu_ack) begin
                lat = n;
                break;
            end
        end
        if (lat < 0) chk_eq("ack_timeout", cpu_ack, 1);
    endtask

    task automatic cpu_read(input logic [13:0] a, input int exp_lat);
        int lat;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_wren = 1'b0;
        cpu_addr = a;
        exp_q.push_back('{rd: 1'b1, data: ref_mem[a]});
        if (exp_lat == 2) begin
            #1;
            chk_eq("rd_issue_addr", ram_addr, a);
        end
        wait_ack(40, lat);
        if (exp_lat > 0) chk_eq("rd_latency", lat, exp_lat);
        cpu_req = 1'b0;
    endtask

    task automatic cpu_write(input logic [13:0] a, input logic [15:0] d, input logic [1:0] sel);
        int lat;
        @(negedge clk);
        cpu_req     = 1'b1;
        cpu_wren    = 1'b1;
        cpu_addr    = a;
        cpu_wrdata  = d;
        cpu_bytesel = sel;
        if (sel[0]) ref_mem[a][7:0]  = d[7:0];
        if (sel[1]) ref_mem[a][15:8] = d[15:8];
        exp_q.push_back('{rd: 1'b0, data: 16'h0000});
`ifndef VRAM_WRBUF_EN
        #1;
        chk_eq("wr_wren", ram_wren, 1);
        chk_eq("wr_addr", ram_addr, a);
        chk_eq("wr_sel", ram_wrsel, sel);
        chk_eq("wr_data", ram_wrdata, d);
`endif
        wait_ack(40, lat);
        chk_eq("wr_latency", lat, 1);
        cpu_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] a;
        logic [15:0] d;
        int          lat;

        reset = 1'b1; ram_init = 1'b1; gfx_active = 1'b0; gfx_addr = 14'h0;
        cpu_req = 1'b0; cpu_wren = 1'b0; cpu_addr = 14'h0; cpu_wrdata = 16'h0; cpu_bytesel = 2'b00;
        for (int i = 0; i < 16384; i++) ref_mem[i] = 16'(i * 7) ^ 16'h5A5A;
        ref_mem[14'h0123] = 16'hBEEF;
        ref_mem[14'h3F00] = 16'hABCD;
        repeat (3) @(negedge clk);
        ram_init = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_eq("rst_ack", cpu_ack, 0);
        chk_eq("rst_rddata", cpu_rddata, 0);
`ifdef VRAM_WRBUF_EN
        chk_eq("rst_wrbuf_empty", wrbuf_empty, 1);
`endif

        // Basic read with gfx idle.
        cpu_read(14'h0123, 2);
        #1;
        chk_eq("gfx_rddata_eq_ram", gfx_rddata, ram_rddata);

        // Low-byte write then readback with high byte preserved.
        cpu_write(14'h3F00, 16'h1234, 2'b01);
        cpu_read(14'h3F00, 2);

        // Mixed writes and reads over assorted patterns.
        for (int i = 0; i < 6; i++) begin
            a = 14'($urandom_range(0, 16383));
            d = 16'($urandom);
            cpu_write(a, d, 2'(i % 3 + 1));
            cpu_read(a, 2);
            cpu_read(14'($urandom_range(0, 16383)), 2);
        end

        // Read held off by 10 gfx cycles; port tracks gfx the whole time.
        @(negedge clk);
        gfx_active = 1'b1;
        cpu_req    = 1'b1;
        cpu_wren   = 1'b0;
        cpu_addr   = 14'h0200;
        exp_q.push_back('{rd: 1'b1, data: ref_mem[14'h0200]});
        for (int i = 0; i < 10; i++) begin
            gfx_addr = 14'h1000 + 14'(i);
            #1;
            chk_eq("hold_gfx_addr", ram_addr, gfx_addr);
            chk_eq("hold_no_ack", cpu_ack, 0);
            @(negedge clk);
        end
        gfx_active = 1'b0;
        #1;
        chk_eq("hold_cpu_issue", ram_addr, 14'h0200);
        wait_ack(10, lat);
        chk_eq("hold_latency", lat, 2);
        cpu_req = 1'b0;

        // gfx takes the port during RD; CPU data still arrives intact.
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_wren = 1'b0;
        cpu_addr = 14'h0300;
        exp_q.push_back('{rd: 1'b1, data: ref_mem[14'h0300]});
        @(negedge clk);
        gfx_active = 1'b1;
        gfx_addr   = 14'h2AAA;
        #1;
        chk_eq("rd_gfx_steal_addr", ram_addr, 14'h2AAA);
        @(negedge clk);
        #1;
        chk_eq("rd_gfx_steal_ack", cpu_ack, 1);
        cpu_req    = 1'b0;
        gfx_active = 1'b0;

        // Reset while in RD drops the access silently.
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_wren = 1'b0;
        cpu_addr = 14'h0055;
        @(negedge clk);
        reset   = 1'b1;
        cpu_req = 1'b0;
        @(negedge clk);
        #1;
        chk_eq("rst_rd_no_ack", cpu_ack, 0);
        chk_eq("rst_rd_rddata", cpu_rddata, 0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        chk_eq("rst_rd_no_ack2", cpu_ack, 0);
        cpu_read(14'h0055, 2);

`ifdef VRAM_WRBUF_EN
        // Posted writes under gfx: four admitted, fifth stalls until the FIFO drains.
        @(negedge clk);
        gfx_active = 1'b1;
        gfx_addr   = 14'h0777;
        wr_log.delete();
        for (int i = 0; i < 4; i++) cpu_write(14'h0400 + 14'(i), 16'hC000 + 16'(i), 2'b11);
        @(negedge clk);
        cpu_req     = 1'b1;
        cpu_wren    = 1'b1;
        cpu_addr    = 14'h0404;
        cpu_wrdata  = 16'hC004;
        cpu_bytesel = 2'b11;
        ref_mem[14'h0404] = 16'hC004;
        exp_q.push_back('{rd: 1'b0, data: 16'h0000});
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk_eq("full_no_ack", cpu_ack, 0);
            chk_eq("full_not_empty", wrbuf_empty, 0);
        end
        @(negedge clk);
        gfx_active = 1'b0;
        wait_ack(10, lat);
        cpu_req = 1'b0;
        cpu_read(14'h0403, 0);
        chk_eq("drain_count", wr_log.size(), 5);
        for (int i = 0; i < 5 && i < wr_log.size(); i++) begin
            chk_eq("drain_addr", wr_log[i].a, 14'h0400 + 14'(i));
            chk_eq("drain_data", wr_log[i].d, 16'hC000 + 16'(i));
        end
        #1;
        chk_eq("drain_empty", wrbuf_empty, 1);
`endif

        repeat (4) @(negedge clk);
        chk_eq("sb_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
